// File: rtl/edge_map_reader_if.sv
// RAM read port and pixel stream between the edge-map reader and its neighbours.
// master = reader side, slave = RAM/consumer side.
interface edge_map_reader_if;
  logic [17:0] address;
  logic        wren;
  logic [31:0] data_read;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        pixel_edge;
  logic [8:0]  pixel_x;
  logic [7:0]  pixel_y;

  modport master (
    output address, wren, pixel_valid, pixel_edge, pixel_x, pixel_y,
    input  data_read, pixel_ready
  );
  modport slave (
    input  address, wren, pixel_valid, pixel_edge, pixel_x, pixel_y,
    output data_read, pixel_ready
  );
endinterface

// File: rtl/edge_map_reader.sv
// Walks the edge-map RAM from START_ADDR to END_ADDR, presenting one edge flag
// per word with its (x, y) position over a valid/ready stream.
module edge_map_reader #(
  parameter int START_ADDR = 2240,
  parameter int END_ADDR   = 74559,
  parameter int LINE_WIDTH = 320
) (
  input  logic                clk_div_by_two,
  input  logic                rst_n,
  input  logic                pause,
  input  logic                enable_edge_readout,
  output logic [17:0]         edge_count,
  output logic                edge_readout_done,
  edge_map_reader_if.master   bus
);

  localparam logic [17:0] START_PTR = 18'(START_ADDR);
  localparam logic [17:0] END_PTR   = 18'(END_ADDR);
  localparam logic [8:0]  START_X   = 9'(START_ADDR % LINE_WIDTH);
  localparam logic [7:0]  START_Y   = 8'(START_ADDR / LINE_WIDTH);
  localparam logic [8:0]  LAST_X    = 9'(LINE_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CAPTURE, PRESENT, DONE} state_t;

  state_t      state;
  logic [17:0] ptr;

  // Only bit 0 of the RAM word carries the edge flag.
  logic unused_data;
  assign unused_data = ^bus.data_read[31:1];

  assign bus.wren = 1'b0;

  always_ff @(posedge clk_div_by_two or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      ptr               <= '0;
      bus.address       <= '0;
      bus.pixel_valid   <= 1'b0;
      bus.pixel_edge    <= 1'b0;
      bus.pixel_x       <= '0;
      bus.pixel_y       <= '0;
      edge_count        <= '0;
      edge_readout_done <= 1'b0;
    end else if (!pause) begin
      // Abort beats every in-flight state; edge_count is kept for inspection.
      if (!enable_edge_readout && state != IDLE) begin
        state             <= IDLE;
        bus.address       <= '0;
        bus.pixel_valid   <= 1'b0;
        edge_readout_done <= 1'b0;
      end else begin
        case (state)
          IDLE: if (enable_edge_readout) begin
            ptr         <= START_PTR;
            bus.pixel_x <= START_X;
            bus.pixel_y <= START_Y;
            edge_count  <= '0;
            state       <= ADDR;
          end
          ADDR: begin
            bus.address <= ptr;
            state       <= WAIT;
          end
          WAIT: state <= CAPTURE;
          CAPTURE: begin
            bus.pixel_edge  <= bus.data_read[0];
            bus.pixel_valid <= 1'b1;
            state           <= PRESENT;
          end
          PRESENT: if (bus.pixel_ready) begin
            bus.pixel_valid <= 1'b0;
            if (bus.pixel_edge && edge_count != '1)
              edge_count <= edge_count + 18'd1;
            if (ptr == END_PTR) begin
              edge_readout_done <= 1'b1;
              state             <= DONE;
            end else begin
              ptr <= ptr + 18'd1;
              if (bus.pixel_x == LAST_X) begin
                bus.pixel_x <= '0;
                bus.pixel_y <= bus.pixel_y + 8'd1;
              end else begin
                bus.pixel_x <= bus.pixel_x + 9'd1;
              end
              state <= ADDR;
            end
          end
          DONE: edge_readout_done <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
